// File: rtl/max_pooling_layer_pkg.sv
// Shared types and helpers for the streaming max-pooling stage.
// Row-phase encoding tells each channel how to treat the row buffer on a window-row boundary.
package max_pooling_layer_pkg;

    typedef enum logic [1:0] {
        PH_FIRST  = 2'd0,
        PH_MIDDLE = 2'd1,
        PH_LAST   = 2'd2
    } row_phase_e;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/max_pooling_layer_if.sv
// Feature-map stream bundle: enable, pixel in with valid, pooled pixel out with valid.
interface max_pooling_layer_if #(
    parameter int D_WIDTH  = 16,
    parameter int CHANNELS = 4
);
    logic                          clk_en;
    logic                          in_valid;
    logic [D_WIDTH*CHANNELS-1:0]   input_data;
    logic [D_WIDTH*CHANNELS-1:0]   output_data;
    logic                          valid;

    modport master (
        output clk_en, in_valid, input_data,
        input  output_data, valid
    );

    modport slave (
        input  clk_en, in_valid, input_data,
        output output_data, valid
    );
endinterface

// File: rtl/max_pooling_layer_channel.sv
// One channel of the pooler: horizontal running max, pooled-column row buffer,
// signed max tree and optional ReLU on the final pooled value.
module max_pool_channel
    import max_pooling_layer_pkg::*;
#(
    parameter int D_WIDTH    = 16,
    parameter int POOL_SIZE  = 2,
    parameter int NUM_POOLED = 12,
    parameter int RELU       = 0,
    localparam int POOL_W    = cnt_width(POOL_SIZE),
    localparam int PC_W      = cnt_width(NUM_POOLED)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accept_i,
    input  logic [POOL_W-1:0]         wc_i,
    input  row_phase_e                phase_i,
    input  logic [PC_W-1:0]           pc_i,
    input  logic signed [D_WIDTH-1:0] x_i,
    output logic signed [D_WIDTH-1:0] result_o
);

    localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL_SIZE - 1);

    logic signed [D_WIDTH-1:0] hmax_q, hmax_d;
    logic signed [D_WIDTH-1:0] out_q, out_d;
    logic signed [D_WIDTH-1:0] rowbuf_q [NUM_POOLED];
    logic signed [D_WIDTH-1:0] rb_rd, h, pooled, rb_wdata;
    logic                      rb_we;

    // Pure compares keep the most negative code safe: nothing is ever negated or subtracted.
    function automatic logic signed [D_WIDTH-1:0] smax(
        input logic signed [D_WIDTH-1:0] a,
        input logic signed [D_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rb_rd    = rowbuf_q[pc_i];
        h        = smax(hmax_q, x_i);
        pooled   = smax(rb_rd, h);
        hmax_d   = hmax_q;
        out_d    = out_q;
        rb_we    = 1'b0;
        rb_wdata = h;

        if (accept_i) begin
            hmax_d = (wc_i == '0) ? x_i : h;
            if (wc_i == POOL_LAST) begin
                unique case (phase_i)
                    PH_FIRST: begin
                        rb_we    = 1'b1;
                        rb_wdata = h;
                    end
                    PH_MIDDLE: begin
                        rb_we    = 1'b1;
                        rb_wdata = pooled;
                    end
                    PH_LAST: begin
                        out_d = (RELU != 0 && pooled < 0) ? '0 : pooled;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hmax_q <= '0;
            out_q  <= '0;
        end else begin
            hmax_q <= hmax_d;
            out_q  <= out_d;
        end
    end

    // NOTE: the row buffer has no reset; the first row of each window always writes an entry before it is read.
    always_ff @(posedge clk) begin
        if (rb_we) begin
            rowbuf_q[pc_i] <= rb_wdata;
        end
    end

    assign result_o = out_q;

endmodule

// File: rtl/max_pooling_layer.sv
// Streaming POOL_SIZE x POOL_SIZE, stride POOL_SIZE max-pooling stage for a raster feature map.
// Owns the raster/window counters and output valid; per-channel datapaths live in max_pool_channel.
module max_pooling_layer
    import max_pooling_layer_pkg::*;
#(
    parameter int D_WIDTH    = 16,
    parameter int CHANNELS   = 4,
    parameter int IMAGE_SIZE = 24,
    parameter int POOL_SIZE  = 2,
    parameter int RELU       = 0
) (
    input logic                  clk,
    input logic                  rst,
    max_pooling_layer_if.slave   bus
);

    localparam int NUM_POOLED = IMAGE_SIZE / POOL_SIZE;
    localparam int CNT_W      = cnt_width(IMAGE_SIZE);
    localparam int POOL_W     = cnt_width(POOL_SIZE);
    localparam int PC_W       = cnt_width(NUM_POOLED);

    localparam logic [CNT_W-1:0]  IMG_LAST  = CNT_W'(IMAGE_SIZE - 1);
    localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL_SIZE - 1);

    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    // Window sub-counters track col/row mod POOL_SIZE and col / POOL_SIZE without dividers.
    logic [POOL_W-1:0] wc_q, wc_d;
    logic [POOL_W-1:0] wr_q, wr_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;

    logic       accept;
    logic       window_done;
    row_phase_e phase;

    assign accept      = bus.clk_en & bus.in_valid;
    assign window_done = accept && (wc_q == POOL_LAST) && (wr_q == POOL_LAST);

    always_comb begin
        phase = PH_MIDDLE;
        if (wr_q == '0) begin
            phase = PH_FIRST;
        end else if (wr_q == POOL_LAST) begin
            phase = PH_LAST;
        end
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        wc_d      = wc_q;
        wr_d      = wr_q;
        pc_d      = pc_q;
        valid_d   = bus.clk_en ? window_done : valid_q;

        if (accept) begin
            if (col_cnt_q == IMG_LAST) begin
                col_cnt_d = '0;
                wc_d      = '0;
                pc_d      = '0;
                if (row_cnt_q == IMG_LAST) begin
                    row_cnt_d = '0;
                    wr_d      = '0;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    wr_d      = (wr_q == POOL_LAST) ? '0 : wr_q + 1'b1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
                if (wc_q == POOL_LAST) begin
                    wc_d = '0;
                    pc_d = pc_q + 1'b1;
                end else begin
                    wc_d = wc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            wc_q      <= '0;
            wr_q      <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            wc_q      <= wc_d;
            wr_q      <= wr_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic signed [D_WIDTH-1:0] result;

        max_pool_channel #(
            .D_WIDTH   (D_WIDTH),
            .POOL_SIZE (POOL_SIZE),
            .NUM_POOLED(NUM_POOLED),
            .RELU      (RELU)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .accept_i(accept),
            .wc_i    (wc_q),
            .phase_i (phase),
            .pc_i    (pc_q),
            .x_i     (bus.input_data[D_WIDTH*i +: D_WIDTH]),
            .result_o(result)
        );

        assign bus.output_data[D_WIDTH*i +: D_WIDTH] = result;
    end

    assign bus.valid = valid_q;

endmodule

// File: tb/tb_max_pooling_layer.sv
// Bench for max_pooling_layer on a 4x4, 2-channel, 8-bit map: a plain DUT and a ReLU DUT
// share one stimulus stream; a frame-buffer model pushes expected windows into a scoreboard.
module tb_max_pooling_layer;

    localparam int DW  = 8;
    localparam int CH  = 2;
    localparam int IMG = 4;
    localparam int PS  = 2;
    localparam int NPIX = IMG * IMG;

    logic clk = 1'b0;
    logic rst;
    logic en, inv;
    logic [DW*CH-1:0] din;

    always #5 clk = ~clk;

    max_pooling_layer_if #(.D_WIDTH(DW), .CHANNELS(CH)) if_a ();
    max_pooling_layer_if #(.D_WIDTH(DW), .CHANNELS(CH)) if_b ();

    assign if_a.clk_en     = en;
    assign if_a.in_valid   = inv;
    assign if_a.input_data = din;
    assign if_b.clk_en     = en;
    assign if_b.in_valid   = inv;
    assign if_b.input_data = din;

    max_pooling_layer #(.D_WIDTH(DW), .CHANNELS(CH), .IMAGE_SIZE(IMG), .POOL_SIZE(PS), .RELU(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    max_pooling_layer #(.D_WIDTH(DW), .CHANNELS(CH), .IMAGE_SIZE(IMG), .POOL_SIZE(PS), .RELU(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    typedef struct packed {
        logic [DW*CH-1:0] plain;
        logic [DW*CH-1:0] relu;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] fr0 [IMG][IMG];
    logic signed [DW-1:0] fr1 [IMG][IMG];
    logic signed [DW-1:0] src0 [NPIX];
    logic signed [DW-1:0] src1 [NPIX];
    int mr = 0;
    int mc = 0;

    logic en_edge = 1'b1;
    logic exp_valid = 1'b0;
    logic prev_va, prev_vb;
    logic [DW*CH-1:0] prev_da, prev_db;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
        return (v < 0) ? '0 : v;
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (en_edge) begin
            chk("valid_plain", 32'(if_a.valid), 32'(exp_valid));
            chk("valid_relu", 32'(if_b.valid), 32'(exp_valid));
            if (exp_valid && sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_plain", 32'(if_a.output_data), 32'(e.plain));
                chk("data_relu", 32'(if_b.output_data), 32'(e.relu));
            end
        end else begin
            chk("hold_valid_plain", 32'(if_a.valid), 32'(prev_va));
            chk("hold_valid_relu", 32'(if_b.valid), 32'(prev_vb));
            chk("hold_data_plain", 32'(if_a.output_data), 32'(prev_da));
            chk("hold_data_relu", 32'(if_b.output_data), 32'(prev_db));
        end
        prev_va = if_a.valid;
        prev_vb = if_b.valid;
        prev_da = if_a.output_data;
        prev_db = if_b.output_data;
    endtask

    // One clock: check what the previous edge produced, drive new inputs, model the next edge.
    task automatic cycle(input logic e, input logic v,
                         input logic signed [DW-1:0] x0, input logic signed [DW-1:0] x1);
        logic signed [DW-1:0] m0, m1;
        @(negedge clk);
        check_outputs();
        en  = e;
        inv = v;
        din = {x1, x0};
        @(posedge clk);
        en_edge   = e;
        exp_valid = 1'b0;
        if (e && v) begin
            fr0[mr][mc] = x0;
            fr1[mr][mc] = x1;
            if ((mr % PS == PS - 1) && (mc % PS == PS - 1)) begin
                m0 = fr0[mr][mc];
                m1 = fr1[mr][mc];
                for (int dr = 0; dr < PS; dr++) begin
                    for (int dc = 0; dc < PS; dc++) begin
                        if (fr0[mr-dr][mc-dc] > m0) m0 = fr0[mr-dr][mc-dc];
                        if (fr1[mr-dr][mc-dc] > m1) m1 = fr1[mr-dr][mc-dc];
                    end
                end
                sb.push_back('{plain: {m1, m0}, relu: {relu(m1), relu(m0)}});
                exp_valid = 1'b1;
            end
            mc++;
            if (mc == IMG) begin
                mc = 0;
                mr = (mr == IMG - 1) ? 0 : mr + 1;
            end
        end
    endtask

    task automatic send_pixels(input int count, input bit stall);
        int i = 0;
        logic e, v;
        while (i < count) begin
            e = 1'b1;
            v = 1'b1;
            if (stall) begin
                e = ($urandom_range(0, 3) != 0);
                v = ($urandom_range(0, 3) != 0);
            end
            if (e && v) begin
                cycle(1'b1, 1'b1, src0[i], src1[i]);
                i++;
            end else begin
                cycle(e, v, DW'($urandom), DW'($urandom));
            end
        end
    endtask

    task automatic drain(input string tag);
        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic load_ramp(input int offset);
        for (int i = 0; i < NPIX; i++) begin
            src0[i] = DW'(i + 1 + offset);
            src1[i] = DW'(-(i + 1) + offset);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        inv = 1'b0;
        din = '0;
        #3;
        chk("reset_valid_plain", 32'(if_a.valid), 32'd0);
        chk("reset_data_plain", 32'(if_a.output_data), 32'd0);
        chk("reset_data_relu", 32'(if_b.output_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Basic 2x2 pooling with the ReLU instance alongside.
        load_ramp(0);
        send_pixels(NPIX, 1'b0);
        drain("basic_drained");

        // Same frame under random clk_en holds and in_valid gaps.
        send_pixels(NPIX, 1'b1);
        drain("stall_drained");

        // Back-to-back frames, second offset by 20, no idle cycle between them.
        send_pixels(NPIX, 1'b0);
        load_ramp(20);
        send_pixels(NPIX, 1'b0);
        drain("b2b_drained");

        // Reset mid-frame, asserted between clock edges.
        load_ramp(0);
        send_pixels(9, 1'b0);
        #3;
        rst = 1'b1;
        inv = 1'b0;
        #1;
        chk("midrst_valid_plain", 32'(if_a.valid), 32'd0);
        chk("midrst_valid_relu", 32'(if_b.valid), 32'd0);
        chk("midrst_data_plain", 32'(if_a.output_data), 32'd0);
        chk("midrst_data_relu", 32'(if_b.output_data), 32'd0);
        mr = 0;
        mc = 0;
        en_edge   = 1'b1;
        exp_valid = 1'b0;
        #2;
        rst = 1'b0;
        send_pixels(NPIX, 1'b0);
        drain("midrst_drained");

        // Extremes: {-128,-128,-128,127} window and an all -128 window.
        for (int i = 0; i < NPIX; i++) begin
            src0[i] = -8'sd128;
            src1[i] = -8'sd128;
        end
        src0[5]  = 8'sd127;
        src0[8]  = 8'sd0;
        src0[9]  = 8'sd5;
        src0[12] = -8'sd7;
        src0[13] = 8'sd3;
        src1[15] = 8'sd127;
        src1[10] = -8'sd1;
        send_pixels(NPIX, 1'b0);
        drain("extreme_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_pooling_layer.md
Name: max_pooling_layer

Overview:
Streaming POOL_SIZE x POOL_SIZE max-pooling stage with stride POOL_SIZE. It sits directly downstream of convolutional_layer and consumes its raster-order feature-map stream (all channels in parallel, qualified by valid). It emits one pooled pixel per window for all channels, with an optional fused ReLU. Its output stream has the same shape as its input (data bus plus valid), so it can feed the next convolutional_layer.

Parameters:
D_WIDTH, 16, signed width of each channel sample on input and output.
CHANNELS, 4, number of parallel channels; equals the upstream Q_CHANNELS.
IMAGE_SIZE, 24, width and height of the input feature map; must be a multiple of POOL_SIZE.
POOL_SIZE, 2, window edge length and stride; must be at least 2.
RELU, 0, when 1, negative pooled results are clamped to 0.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
clk_en  input  1  global pipeline enable; no state changes while 0.
in_valid  input  1  input_data carries a feature-map pixel (driven by the upstream valid).
input_data  input  D_WIDTH*CHANNELS  channel i occupies bits [D_WIDTH*(i+1)-1 : D_WIDTH*i]; two's complement.
output_data  output  D_WIDTH*CHANNELS  pooled pixel, same packing as input_data.
valid  output  1  output_data holds a new pooled pixel.

Behaviour:
- Reset and clocking: one clock (clk). Reset is asynchronous, active-high (rst), and overrides clk_en.
- Reset values: col_cnt=0, row_cnt=0, valid=0, output_data=0, horizontal-max registers=0. Row-buffer contents are don't-care because they are always overwritten before they are read.
- Accept rule: a pixel is accepted on a rising edge with clk_en=1 and in_valid=1. An edge with clk_en=0 holds all state, including valid and output_data.
- Counters: col_cnt runs 0..IMAGE_SIZE-1 and advances on every accepted pixel. When col_cnt wraps, row_cnt increments over 0..IMAGE_SIZE-1. Both wrap to 0 after pixel (IMAGE_SIZE-1, IMAGE_SIZE-1), so back-to-back frames need no gap.
- Derived indices: wc = col_cnt mod POOL_SIZE, wr = row_cnt mod POOL_SIZE, pc = col_cnt / POOL_SIZE. Counter widths use `LOG2 from definitions.v.
- Per channel, signed compare throughout:
  - hmax = x when wc=0; otherwise hmax = max(hmax, x).
  - When wc=POOL_SIZE-1, let h = max(hmax, x).
  - If wr=0: rowbuf[pc] = h.
  - If 0<wr<POOL_SIZE-1: rowbuf[pc] = max(rowbuf[pc], h).
  - If wr=POOL_SIZE-1: result = max(rowbuf[pc], h); rowbuf is not written.
- Row buffer: IMAGE_SIZE/POOL_SIZE entries per channel, register-based, one read and one write of the same entry per accepted pixel.
- Output:
  - On the enabled edge that accepts the last pixel of a window (wc=wr=POOL_SIZE-1), valid<=1 and output_data<=result, or max(result,0) when RELU=1.
  - Latency is 1 enabled cycle from acceptance of the window's final pixel.
  - On any other enabled edge, valid<=0 and output_data holds its last value.
- Gaps: in_valid=0 on an enabled edge changes no counters or maxima and clears valid.
- Ties and extremes: equal values pick either operand (same value). The most negative value is handled with no overflow, since only compares are performed and no arithmetic.
- Output rate: IMAGE_SIZE²/POOL_SIZE² pooled pixels per frame, in raster order of pooled coordinates.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0).

Decomposition:
- The `LOG2, `L and `R macros come from common/definitions.v.
- Window-position constants (NUM_POOLED = IMAGE_SIZE/POOL_SIZE, counter widths) are local parameters of the top module.
- One sub-module, max_pool_channel, is instantiated CHANNELS times in a generate loop. Each instance holds hmax, the rowbuf array, the signed max logic and optional ReLU, and takes wc/wr/pc plus an accept strobe from the top.
- The top owns the counters, the valid register and the channel packing.

Test Plan:
- Basic 2x2 pooling. Setup: IMAGE_SIZE=4, POOL_SIZE=2, CHANNELS=2, D_WIDTH=8, RELU=0, clk_en=1. Stimulus: ch0 = 1..16 in raster order, ch1 = -1..-16, in_valid held high. Expected: valid pulses one cycle after pixels 5, 7, 13 and 15; ch0 = 6, 8, 14, 16; ch1 = -1, -3, -9, -11.
- ReLU. Same stimulus with RELU=1. Expected: ch0 = 6, 8, 14, 16; ch1 = 0, 0, 0, 0.
- Stalls. Same frame with clk_en=0 on random cycles and in_valid=0 gaps inserted. Expected: identical output sequence; valid never repeats during a clk_en=0 hold; no output during gaps.
- Back-to-back frames. Two frames with no gap, frame 2 = frame 1 + 20. Expected: 8 outputs; frame 2 ch0 = 26, 28, 34, 36. Verifies counter wrap.
- Reset mid-frame. Assert rst asynchronously (not on a clock edge) after pixel 9. Expected: valid=0 and output_data=0 immediately. Then send a full frame; the outputs match the basic 2x2 pooling test.
- Extremes. Window contains -128, -128, -128, 127, plus an all -128 window. Expected: 127 and -128 respectively.
